// File: rtl/pwm_hwdet_mc.sv
// pwm_hwdet_mc: multi-channel PWM high/low time detector.
// Each channel synchronises an asynchronous PWM pin, measures high and low
// times in sysclk cycles, publishes a registered result pair with a
// one-cycle valid strobe, and flags a stuck or absent input.
//
// Optional feature: define HWDET_GLITCH_FILTER_EN to insert a per-channel
// glitch filter (GLITCH_CYC consecutive equal samples) after the synchroniser.
//
// Ports:
//   sysclk      system clock, rising edge
//   sysreset_n  asynchronous active-low reset
//   pwm_in      asynchronous PWM inputs, one bit per channel
//   ch_en       per-channel enable, synchronous to sysclk
//   high_cnt    last high time, channel i at [i*CNT_W +: CNT_W]
//   low_cnt     last low time, same packing
//   valid       one-cycle strobe when a channel's results update
//   stuck       counter for the current level saturated without an edge
module pwm_hwdet_mc #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 3,
    parameter int unsigned GLITCH_CYC  = 4
) (
    input  logic                    sysclk,
    input  logic                    sysreset_n,
    input  logic [NUM_CH-1:0]       pwm_in,
    input  logic [NUM_CH-1:0]       ch_en,
    output logic [NUM_CH*CNT_W-1:0] high_cnt,
    output logic [NUM_CH*CNT_W-1:0] low_cnt,
    output logic [NUM_CH-1:0]       valid,
    output logic [NUM_CH-1:0]       stuck
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } state_t;

`ifdef HWDET_GLITCH_FILTER_EN
    localparam int unsigned GW = $clog2(GLITCH_CYC + 1);
`else
    // Filter is compiled out; GLITCH_CYC has no effect in this build.
    logic glitch_cyc_unused;
    assign glitch_cyc_unused = ^32'(GLITCH_CYC);
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   lvl;
        logic                   lvl_d;
        logic                   rise;
        logic                   fall;
        state_t                 state_q;
        state_t                 state_d;
        logic [CNT_W-1:0]       hi_run_q;
        logic [CNT_W-1:0]       hi_run_d;
        logic [CNT_W-1:0]       lo_run_q;
        logic [CNT_W-1:0]       lo_run_d;
        logic [CNT_W-1:0]       high_q;
        logic [CNT_W-1:0]       high_d;
        logic [CNT_W-1:0]       low_q;
        logic [CNT_W-1:0]       low_d;
        logic                   valid_q;
        logic                   valid_d;
        logic                   stuck_q;
        logic                   stuck_d;
        logic                   armed;
        logic                   fall_seen;
        logic                   hi_sat;
        logic                   lo_sat;

        // Input synchroniser plus one-cycle delayed level for edge detection
        always_ff @(posedge sysclk or negedge sysreset_n) begin
            if (!sysreset_n) begin
                sync_q <= '0;
                lvl_d  <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in[i]};
                lvl_d  <= lvl;
            end
        end

`ifdef HWDET_GLITCH_FILTER_EN
        logic [GW-1:0] gcnt_q;
        logic          flt_q;
        logic          differ;
        logic          settle;

        // The GLITCH_CYC-th differing sample passes straight through to lvl,
        // so the filter adds GLITCH_CYC-1 cycles of latency.
        assign differ = sync_q[SYNC_STAGES-1] ^ flt_q;
        assign settle = differ && (gcnt_q == GW'(GLITCH_CYC - 1));
        assign lvl    = settle ? sync_q[SYNC_STAGES-1] : flt_q;

        always_ff @(posedge sysclk or negedge sysreset_n) begin
            if (!sysreset_n) begin
                gcnt_q <= '0;
                flt_q  <= 1'b0;
            end else if (settle) begin
                gcnt_q <= '0;
                flt_q  <= sync_q[SYNC_STAGES-1];
            end else if (differ) begin
                gcnt_q <= gcnt_q + GW'(1);
            end else begin
                gcnt_q <= '0;
            end
        end
`else
        assign lvl = sync_q[SYNC_STAGES-1];
`endif

        assign rise      = lvl & ~lvl_d;
        assign fall      = ~lvl & lvl_d;
        assign armed     = (state_q == MEAS_HIGH) || (state_q == MEAS_LOW);
        assign fall_seen = (state_q == MEAS_LOW);
        assign hi_sat    = (hi_run_q == CNT_MAX);
        assign lo_sat    = (lo_run_q == CNT_MAX);

        // State, counters and result registers
        always_ff @(posedge sysclk or negedge sysreset_n) begin
            if (!sysreset_n) begin
                state_q  <= IDLE;
                hi_run_q <= '0;
                lo_run_q <= '0;
                high_q   <= '0;
                low_q    <= '0;
                valid_q  <= 1'b0;
                stuck_q  <= 1'b0;
            end else begin
                state_q  <= state_d;
                hi_run_q <= hi_run_d;
                lo_run_q <= lo_run_d;
                high_q   <= high_d;
                low_q    <= low_d;
                valid_q  <= valid_d;
                stuck_q  <= stuck_d;
            end
        end

        // Next-state, counting, saturation and capture
        always_comb begin
            state_d  = state_q;
            hi_run_d = hi_run_q;
            lo_run_d = lo_run_q;
            high_d   = high_q;
            low_d    = low_q;
            valid_d  = 1'b0;
            stuck_d  = stuck_q;

            if (!ch_en[i]) begin
                // Disable wins over any edge this cycle; results hold.
                state_d  = IDLE;
                hi_run_d = '0;
                lo_run_d = '0;
                stuck_d  = 1'b0;
            end else begin
                case (state_q)
                    IDLE:      state_d = WAIT_RISE;
                    WAIT_RISE: if (rise) state_d = MEAS_HIGH;
                    MEAS_HIGH: if (fall) state_d = MEAS_LOW;
                    MEAS_LOW:  if (rise) state_d = MEAS_HIGH;
                    default:   state_d = IDLE;
                endcase

                if (state_q != IDLE) begin
                    if (rise) begin
                        hi_run_d = CNT_W'(1);
                        lo_run_d = '0;
                    end else if (fall) begin
                        lo_run_d = CNT_W'(1);
                    end else if (lvl) begin
                        if (!hi_sat) hi_run_d = hi_run_q + CNT_W'(1);
                    end else begin
                        if (!lo_sat) lo_run_d = lo_run_q + CNT_W'(1);
                    end

                    // Stuck rises the cycle after saturation, clears on any edge
                    if (rise || fall) begin
                        stuck_d = 1'b0;
                    end else if (lvl ? hi_sat : lo_sat) begin
                        stuck_d = 1'b1;
                    end

                    // A period with a saturated counter is discarded
                    if (rise && armed && fall_seen && !hi_sat && !lo_sat) begin
                        high_d  = hi_run_q;
                        low_d   = lo_run_q;
                        valid_d = 1'b1;
                    end
                end
            end
        end

        assign high_cnt[i*CNT_W +: CNT_W] = high_q;
        assign low_cnt[i*CNT_W +: CNT_W]  = low_q;
        assign valid[i]                   = valid_q;
        assign stuck[i]                   = stuck_q;
    end

endmodule

// File: tb/tb_pwm_hwdet_mc.sv
// Self-checking bench for pwm_hwdet_mc (2 channels, 16-bit counters,
// 3-stage synchroniser). Expected result pairs are queued as stimulus is
// issued; a monitor pops and compares whenever a valid strobe appears.
module tb_pwm_hwdet_mc;

    logic        sysclk = 1'b0;
    logic        sysreset_n;
    logic [1:0]  pwm_in;
    logic [1:0]  ch_en;
    logic [31:0] high_cnt;
    logic [31:0] low_cnt;
    logic [1:0]  valid;
    logic [1:0]  stuck;

    int checks  = 0;
    int errors  = 0;
    int sim_cnt = 0;

    // {high, low} expected per channel
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    pwm_hwdet_mc #(
        .NUM_CH     (2),
        .CNT_W      (16),
        .SYNC_STAGES(3),
        .GLITCH_CYC (4)
    ) dut (
        .sysclk    (sysclk),
        .sysreset_n(sysreset_n),
        .pwm_in    (pwm_in),
        .ch_en     (ch_en),
        .high_cnt  (high_cnt),
        .low_cnt   (low_cnt),
        .valid     (valid),
        .stuck     (stuck)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic exp0(input int h, input int l);
        q0.push_back({16'(h), 16'(l)});
    endtask

    task automatic exp1(input int h, input int l);
        q1.push_back({16'(h), 16'(l)});
    endtask

    task automatic check_pop(input int ch);
        logic [31:0] e;
        logic [15:0] ah;
        logic [15:0] al;
        int          qs;
        ah = (ch == 0) ? high_cnt[15:0] : high_cnt[31:16];
        al = (ch == 0) ? low_cnt[15:0]  : low_cnt[31:16];
        qs = (ch == 0) ? q0.size() : q1.size();
        if (qs == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid ch%0d: got high %0d low %0d, required no valid", ch, ah, al);
        end else begin
            e = (ch == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("high_cnt ch%0d", ch), 32'(ah), 32'(e[31:16]));
            chk($sformatf("low_cnt ch%0d", ch), 32'(al), 32'(e[15:0]));
        end
    endtask

    // Monitor: compare every valid strobe against the scoreboard
    always @(negedge sysclk) begin
        if (sysreset_n === 1'b1) begin
            if (valid[0]) check_pop(0);
            if (valid[1]) check_pop(1);
            if (valid == 2'b11) sim_cnt++;
        end
    end

    // Hold pins at v for n clock cycles; call at a falling edge
    task automatic hold(input logic [1:0] v, input int n);
        pwm_in = v;
        repeat (n) @(negedge sysclk);
    endtask

    // Disable all channels with pins low, then enable the given mask
    task automatic quiesce(input logic [1:0] en);
        ch_en = 2'b00;
        hold(2'b00, 10);
        ch_en = en;
        hold(2'b00, 10);
    endtask

    initial begin
        sysreset_n = 1'b0;
        pwm_in     = 2'b00;
        ch_en      = 2'b00;
        #1;
        chk("reset high_cnt", high_cnt, 32'd0);
        chk("reset low_cnt", low_cnt, 32'd0);
        chk("reset valid", 32'(valid), 32'd0);
        chk("reset stuck", 32'(stuck), 32'd0);
        repeat (3) @(negedge sysclk);
        sysreset_n = 1'b1;

        // 30/70 on ch0, ch1 idle low: first rise only arms
        quiesce(2'b11);
        for (int k = 0; k < 4; k++) exp0(30, 70);
        for (int k = 0; k < 4; k++) begin
            hold(2'b01, 30);
            hold(2'b00, 70);
        end
        hold(2'b01, 10);

        // Enable drop mid high period: results hold, re-arm needed
        hold(2'b01, 5);
        ch_en = 2'b10;
        hold(2'b01, 10);
        chk("disabled high_cnt ch0", 32'(high_cnt[15:0]), 32'd30);
        chk("disabled low_cnt ch0", 32'(low_cnt[15:0]), 32'd70);
        chk("disabled stuck ch0", 32'(stuck[0]), 32'd0);
        hold(2'b01, 10);
        ch_en = 2'b11;
        exp0(30, 70);
        hold(2'b01, 5);
        hold(2'b00, 70);
        hold(2'b01, 30);
        hold(2'b00, 70);
        hold(2'b01, 10);

        // Asynchronous reset mid high period
        chk("pre-reset high_cnt ch0", 32'(high_cnt[15:0]), 32'd30);
        #2;
        sysreset_n = 1'b0;
        #1;
        chk("async reset high_cnt", high_cnt, 32'd0);
        chk("async reset low_cnt", low_cnt, 32'd0);
        chk("async reset valid", 32'(valid), 32'd0);
        chk("async reset stuck", 32'(stuck), 32'd0);
        pwm_in = 2'b00;
        repeat (5) @(negedge sysclk);
        sysreset_n = 1'b1;
        exp0(25, 75);
        hold(2'b00, 10);
        hold(2'b01, 25);
        hold(2'b00, 75);
        hold(2'b01, 10);

        // Two channels with aligned rising edges: 10/90 and 50/50
        quiesce(2'b11);
        for (int k = 0; k < 3; k++) begin
            exp0(10, 90);
            exp1(50, 50);
        end
        for (int k = 0; k < 3; k++) begin
            hold(2'b11, 10);
            hold(2'b10, 40);
            hold(2'b00, 50);
        end
        hold(2'b11, 10);

        // Stuck high: saturation, no capture, clear on fall, then recovery
        quiesce(2'b01);
        exp0(30, 70);
        hold(2'b01, 65000);
        chk("stuck before saturation", 32'(stuck[0]), 32'd0);
        hold(2'b01, 1000);
        chk("stuck after saturation", 32'(stuck[0]), 32'd1);
        hold(2'b00, 20);
        chk("stuck cleared by fall", 32'(stuck[0]), 32'd0);
        hold(2'b00, 50);
        hold(2'b01, 30);
        hold(2'b00, 70);
        hold(2'b01, 10);

        // 2-cycle glitch inside a 70-cycle low period
        quiesce(2'b01);
`ifdef HWDET_GLITCH_FILTER_EN
        exp0(30, 70);
        exp0(30, 70);
`else
        exp0(30, 30);
        exp0(2, 38);
        exp0(30, 70);
`endif
        hold(2'b01, 30);
        hold(2'b00, 30);
        hold(2'b01, 2);
        hold(2'b00, 38);
        hold(2'b01, 30);
        hold(2'b00, 70);
        hold(2'b01, 10);

        hold(2'b00, 20);
        chk("pending ch0 results", 32'(q0.size()), 32'd0);
        chk("pending ch1 results", 32'(q1.size()), 32'd0);
        chk("simultaneous valids", 32'(sim_cnt), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_hwdet_mc.md
# pwm_hwdet_mc

Multi-channel hardware pulse-width detector: the parametrised successor to the single-channel HWDET path that sits between the light-sensor PWM pins and the EMBSYS Microblaze. Each channel synchronises one asynchronous PWM input and measures its high time and low time in `sysclk` cycles. Each channel publishes a registered result pair with a one-cycle valid strobe. Each channel flags a stuck or absent input. The block instantiates next to EMBSYS in the top level, and its result buses feed GPIO or AXI registers.

## Interface
- `NUM_CH`, 4: number of independent PWM channels (1–16).
- `CNT_W`, 16: width of the high/low counters and of the results.
- `SYNC_STAGES`, 3: flip-flops in each input synchroniser (2–4).
- `GLITCH_CYC`, 4: stable-sample count for the glitch filter; used only when the filter is compiled in.

- `sysclk`  in  1  100 MHz system clock; every flop is clocked on its rising edge.
- `sysreset_n`  in  1  reset, asynchronous and active-low.
- `pwm_in`  in  NUM_CH  asynchronous PWM inputs, one per channel.
- `ch_en`  in  NUM_CH  per-channel enable, synchronous to `sysclk`.
- `high_cnt`  out  NUM_CH*CNT_W  last measured high time; channel i occupies bits [i*CNT_W +: CNT_W].
- `low_cnt`  out  NUM_CH*CNT_W  last measured low time; same packing as `high_cnt`.
- `valid`  out  NUM_CH  one-cycle strobe: the channel's results updated this cycle.
- `stuck`  out  NUM_CH  channel saw no edge before a running counter saturated.

## Operation
- **Reset.** While `sysreset_n` is low, all synchroniser flops, running counters, results, `valid`, `stuck` and the `armed`/`fall_seen` flags clear to 0. Reset takes effect immediately, mid-period or not.
- **Synchroniser.** Each channel has a SYNC_STAGES-deep chain. The last stage, `lvl`, is the filtered level (see Configuration). `lvl_d` is `lvl` delayed one cycle.
- **Edge detect.** `rise` = `lvl & ~lvl_d`. `fall` = `~lvl & lvl_d`.
- **Per-channel states.** Each channel has four states:
  - IDLE: `ch_en` is 0.
  - WAIT_RISE: enabled, not armed.
  - MEAS_HIGH: armed, `lvl` = 1.
  - MEAS_LOW: armed, `lvl` = 0.
- **Transitions.**
  - IDLE to WAIT_RISE: on `ch_en` = 1.
  - WAIT_RISE to MEAS_HIGH: on `rise`. This sets `armed`.
  - MEAS_HIGH to MEAS_LOW: on `fall`. This sets `fall_seen`.
  - MEAS_LOW to MEAS_HIGH: on `rise`.
  - Any state to IDLE: on `ch_en` = 0. This clears the counters, `armed`, `fall_seen` and `stuck`. Results hold their last values.
- **Counting.**
  - In a `rise` cycle: `hi_run` <= 1, `lo_run` <= 0.
  - In a `fall` cycle: `lo_run` <= 1.
  - Otherwise the counter matching `lvl` increments.
  - Both counters saturate at 2^CNT_W−1 and never wrap.
- **Capture.** A capture happens on `rise` when `armed`, `fall_seen`, and neither run counter is saturated. On capture:
  - `high_cnt` <= `hi_run` and `low_cnt` <= `lo_run`, registered.
  - `valid` pulses for exactly one cycle.
  - `fall_seen` clears.
- **No capture on the first rise.** The first rise after reset or enable only arms the channel; it is a partial period.
- **Saturation.**
  - When the counter for the current level reaches its maximum, `stuck` is set on the next cycle. `stuck` stays high until the next edge of either polarity, which clears it.
  - A period in which either counter saturated produces no capture and no `valid`.
- **Channel independence.** Channels share no state. Simultaneous edges on any number of channels are each handled in the same cycle.

## Timing
- From a `pwm_in` transition, `lvl` changes SYNC_STAGES cycles later when the filter is off. With the filter on, it changes SYNC_STAGES+GLITCH_CYC−1 cycles later.
- `rise` and `fall` are combinational in the cycle `lvl` changes.
- `high_cnt`, `low_cnt` and `valid` update on the next clock edge.
- Pin-to-`valid` latency is SYNC_STAGES+1 cycles with the filter off.
- Measured values equal the true pulse widths in cycles, ±1 for synchroniser sampling.
- `ch_en` falling takes effect on the next clock edge. A `rise` in that same cycle is ignored.

## Configuration
- **Macro `HWDET_GLITCH_FILTER_EN`.**
- **Defined:** after the synchroniser, a per-channel counter requires GLITCH_CYC consecutive equal samples before `lvl` changes. Pulses shorter than GLITCH_CYC cycles are discarded entirely, produce no edges, and their cycles count toward the surrounding level.
- **Undefined:** `lvl` is the synchroniser output directly, GLITCH_CYC is ignored, and the filter logic is absent.

## Test plan
1. Configuration NUM_CH=2, CNT_W=16, SYNC_STAGES=3, filter off. Drive `pwm_in[0]` 30 cycles high / 70 cycles low, `ch_en`=2'b11.
   - No `valid` on the first rise.
   - From the second rise onward, `valid[0]` pulses every 100 cycles with `high_cnt`=30 and `low_cnt`=70.
   - `valid[1]` stays 0.
2. Drive ch0 at 10/90 and ch1 at 50/50, with edges aligned on the same cycle.
   - Both `valid` bits strobe in the same cycle.
   - Results are 10/90 and 50/50 with no cross-talk.
3. Hold `pwm_in[0]` high for 70000 cycles after arming.
   - `stuck[0]`=1 after `hi_run` reaches 65535.
   - No `valid`.
   - On the next fall, `stuck[0]` clears.
   - The first subsequent valid period reports correct values.
4. Assert `sysreset_n`=0 for 5 cycles mid-high-period while `high_cnt`=30.
   - All outputs read 0 immediately, without waiting for a clock edge.
   - After release, the first `valid` requires two rises again.
5. Drop `ch_en[0]` for 20 cycles mid-period.
   - `high_cnt` and `low_cnt` hold 30/70.
   - `stuck[0]`=0.
   - After re-enable, the first valid result reappears only after two rises.
6. With `HWDET_GLITCH_FILTER_EN` and GLITCH_CYC=4, inject a 2-cycle high pulse into a 70-cycle low period.
   - Reported `low_cnt` stays 70 and no extra `valid` occurs.
   - With the macro undefined, the same stimulus produces `high_cnt`=2.
